// File: rtl/divclk_period_meter.sv
// divclk_period_meter: times the divided clock in clk_in cycles.
// Reports period/high time over valid/ready and flags a stalled div_clk.
module divclk_period_meter #(
    parameter int          CNT_WIDTH = 26,
    parameter int unsigned TIMEOUT   = 2**26 - 1
) (
    input  logic                 clk_in,
    input  logic                 nrst,
    input  logic                 div_clk,
    input  logic                 bypass,
    input  logic                 meas_ready,
    input  logic                 clr_sticky,
    output logic                 rise_strb,
    output logic                 meas_valid,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 stalled,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEASURE,
        STALL,
        BYPASS
    } state_t;

    state_t state_q;
    state_t state_d;

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic cap;
    logic xfer;
    logic drop;

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hcnt;

    assign rise = s2 & ~s3;
    assign cap  = (state_q == MEASURE) & rise & ~bypass;
    assign xfer = meas_valid & meas_ready;
    assign drop = cap & meas_valid & ~meas_ready;

    assign stalled = (state_q == STALL);

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q <= WAIT_RISE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bypass overrides every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_RISE: if (rise) state_d = MEASURE;
            MEASURE:   if (!rise && cnt >= TMO) state_d = STALL;
            STALL:     if (rise) state_d = MEASURE;
            BYPASS:    if (!bypass) state_d = WAIT_RISE;
        endcase
        if (bypass) begin
            state_d = BYPASS;
        end
    end

    // Period and high-time counters; hcnt stops once s2 falls.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (bypass || state_q == BYPASS) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
        end else if (state_q == MEASURE) begin
            if (cnt != '1) begin
                cnt <= cnt + ONE;
            end
            if (s2 && hcnt != '1) begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    // Result registers, handshake and sticky overrun flag.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            rise_strb  <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            overrun    <= 1'b0;
        end else begin
            rise_strb <= rise & ~bypass;
            if (bypass) begin
                meas_valid <= 1'b1;
                period     <= ONE;
                high_time  <= '0;
            end else if (state_q == BYPASS) begin
                meas_valid <= 1'b0;
                period     <= '0;
                high_time  <= '0;
            end else if (cap && (!meas_valid || meas_ready)) begin
                meas_valid <= 1'b1;
                period     <= cnt;
                high_time  <= hcnt;
            end else if (xfer) begin
                meas_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_sticky) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divclk_period_meter.sv
// tb_divclk_period_meter: table-driven and hand-written checks
// with a scoreboard queue of expected period/high-time results.
module tb_divclk_period_meter;

    localparam int W   = 26;
    localparam int TMO = 100;

    logic         clk_in     = 1'b0;
    logic         nrst       = 1'b1;
    logic         div_clk    = 1'b0;
    logic         bypass     = 1'b0;
    logic         meas_ready = 1'b0;
    logic         clr_sticky = 1'b0;
    logic         rise_strb;
    logic         meas_valid;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         stalled;
    logic         overrun;

    divclk_period_meter #(
        .CNT_WIDTH(W),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_in    (clk_in),
        .nrst      (nrst),
        .div_clk   (div_clk),
        .bypass    (bypass),
        .meas_ready(meas_ready),
        .clr_sticky(clr_sticky),
        .rise_strb (rise_strb),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .stalled   (stalled),
        .overrun   (overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    typedef struct {
        int per;
        int hi;
        int ncyc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[6];
    int   k;
    int   bad;
    int   v;
    int   s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic outs_zero(input string p);
        chk({p, "_strb"}, int'(rise_strb), 0);
        chk({p, "_valid"}, int'(meas_valid), 0);
        chk({p, "_period"}, int'(period), 0);
        chk({p, "_high"}, int'(high_time), 0);
        chk({p, "_stalled"}, int'(stalled), 0);
        chk({p, "_overrun"}, int'(overrun), 0);
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset(input string p);
        @(negedge clk_in);
        div_clk    = 1'b0;
        bypass     = 1'b0;
        clr_sticky = 1'b0;
        meas_ready = 1'b0;
        #3;
        nrst = 1'b0;
        #1;
        outs_zero(p);
        sb.delete();
        @(negedge clk_in);
        nrst = 1'b1;
    endtask

    // One div_clk cycle starting with its rising edge.
    task automatic gen(input int per, input int hi, input bit push);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        if (push) sb.push_back(e);
        div_clk = 1'b1;
        repeat (hi) @(negedge clk_in);
        div_clk = 1'b0;
        repeat (per - hi) @(negedge clk_in);
    endtask

    task automatic strb_latency(input string nm);
        int n;
        n = 0;
        while (rise_strb !== 1'b1 && n < 10) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk(nm, n, 3);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk_in);
            #1;
            if (meas_valid) cnt++;
        end
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (meas_valid !== 1'b1 && n < 10) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk(nm, n, 3);
    endtask

    // Scoreboard consumer: compare every transfer against the queue head.
    always begin
        @(negedge clk_in);
        #1;
        if (mon_en && meas_valid && meas_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_period", int'(period), mon_e.per);
                chk("sb_high", int'(high_time), mon_e.hi);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        tbl[0] = '{10, 5, 4};
        tbl[1] = '{6, 3, 3};
        tbl[2] = '{4, 2, 3};
        tbl[3] = '{7, 1, 2};
        tbl[4] = '{2, 1, 3};
        tbl[5] = '{9, 8, 2};

        #1 nrst = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        outs_zero("rst");
        @(negedge clk_in);
        nrst = 1'b1;

        // Streaming measurements with meas_ready held high.
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int j = 0; j < tbl[i].ncyc; j++) begin
                        gen(tbl[i].per, tbl[i].hi, 1'b1);
                    end
                end
            end
            strb_latency("first_strb_lat");
        join
        gen(3, 1, 1'b0);
        repeat (8) @(negedge clk_in);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("s1_overrun", int'(overrun), 0);
        mon_en = 1'b0;

        // Back-pressure: old result kept, later captures dropped.
        async_reset("s1rst");
        gen(6, 3, 1'b0);
        #1;
        chk("s2_no_first", int'(meas_valid), 0);
        gen(6, 3, 1'b0);
        #1;
        chk("s2_valid", int'(meas_valid), 1);
        chk("s2_period", int'(period), 6);
        chk("s2_high", int'(high_time), 3);
        chk("s2_ovr0", int'(overrun), 0);
        gen(6, 3, 1'b0);
        #1;
        chk("s2_keep_valid", int'(meas_valid), 1);
        chk("s2_keep_period", int'(period), 6);
        chk("s2_ovr1", int'(overrun), 1);
        @(negedge clk_in);
        clr_sticky = 1'b1;
        @(negedge clk_in);
        clr_sticky = 1'b0;
        #1;
        chk("s2_clr", int'(overrun), 0);
        chk("s2_valid_after_clr", int'(meas_valid), 1);

        // Async reset while holding a result, then normal recovery.
        async_reset("s5rst");
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        fork
            begin
                gen(10, 5, 1'b1);
                gen(10, 5, 1'b1);
                gen(10, 5, 1'b1);
            end
            strb_latency("rec_strb_lat");
        join
        gen(3, 1, 1'b0);
        repeat (8) @(negedge clk_in);
        #1;
        chk("rec_drained", sb.size(), 0);
        mon_en = 1'b0;

        // Stall detection and restart.
        async_reset("s3rst");
        meas_ready = 1'b1;
        gen(4, 2, 1'b0);
        div_clk = 1'b1;
        strb_latency("s3_lat2");
        div_clk = 1'b0;
        chk("s3_pre", int'(stalled), 0);
        k = 0;
        while (stalled !== 1'b1 && k < 300) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        chk("stall_delay", k, TMO);
        div_clk = 1'b1;
        strb_latency("s3_restart_lat");
        chk("s3_stall_clr", int'(stalled), 0);
        bad     = int'(meas_valid);
        div_clk = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            #1;
            bad += int'(meas_valid);
        end
        chk("s3_no_first", bad, 0);
        div_clk = 1'b1;
        wait_valid("s3_val_lat");
        chk("s3_period", int'(period), 6);
        chk("s3_high", int'(high_time), 3);
        div_clk = 1'b0;

        // Bypass entered mid-measurement, then left again.
        async_reset("s4rst");
        gen(10, 5, 1'b0);
        gen(10, 5, 1'b0);
        #1;
        chk("s4_pre_valid", int'(meas_valid), 1);
        chk("s4_pre_period", int'(period), 10);
        @(negedge clk_in);
        bypass = 1'b1;
        @(negedge clk_in);
        #1;
        chk("byp_valid", int'(meas_valid), 1);
        chk("byp_period", int'(period), 1);
        chk("byp_high", int'(high_time), 0);
        chk("byp_strb", int'(rise_strb), 0);
        chk("byp_stalled", int'(stalled), 0);
        meas_ready = 1'b1;
        s = 0;
        v = 0;
        for (int i = 0; i < 12; i++) begin
            div_clk = i[1];
            @(negedge clk_in);
            #1;
            if (rise_strb) s++;
            if (!meas_valid) v++;
        end
        chk("byp_strb_quiet", s, 0);
        chk("byp_valid_held", v, 0);
        chk("byp_period_held", int'(period), 1);
        bypass  = 1'b0;
        div_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        fork
            gen(7, 3, 1'b0);
            count_valid(7, v);
        join
        chk("s4_no_first", v, 0);
        div_clk = 1'b1;
        wait_valid("s4_val_lat");
        chk("s4_period", int'(period), 7);
        chk("s4_high", int'(high_time), 3);
        div_clk = 1'b0;

        // Capture coinciding with a transfer.
        async_reset("s6rst");
        gen(4, 2, 1'b0);
        gen(5, 1, 1'b0);
        #1;
        chk("s6_old_valid", int'(meas_valid), 1);
        chk("s6_old_period", int'(period), 4);
        chk("s6_old_high", int'(high_time), 2);
        div_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        meas_ready = 1'b1;
        #1;
        chk("s6_stable_period", int'(period), 4);
        @(negedge clk_in);
        meas_ready = 1'b0;
        #1;
        chk("s6_valid", int'(meas_valid), 1);
        chk("s6_period", int'(period), 5);
        chk("s6_high", int'(high_time), 1);
        chk("s6_overrun", int'(overrun), 0);
        div_clk = 1'b0;
        @(negedge clk_in);
        meas_ready = 1'b1;
        @(negedge clk_in);
        meas_ready = 1'b0;
        #1;
        chk("s6_drop_valid", int'(meas_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
